// File: rtl/vga_pkg.sv
// Shared VGA definitions.
// - sched_state_t : state encoding of the VRAM access scheduler
//                   (ST_IDLE, ST_RD, ST_WR0, ST_WR1).
// - H_*/V_*       : 640x480@60 timing constants used by the sync controller.
// - is_frame_start: true on the first pixel of a frame (hcount==0, vcount==0).
package vga_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR0  = 2'd2,
    ST_WR1  = 2'd3
  } sched_state_t;

  localparam int H_VISIBLE = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

  localparam int V_VISIBLE = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;
  localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  function automatic logic is_frame_start(input logic [9:0] h, input logic [9:0] v);
    return (h == 10'd0) && (v == 10'd0);
  endfunction

endpackage

// File: rtl/vram_scheduler_if.sv
// Bus bundle between the VRAM scheduler and its neighbours.
// - sync controller side : bright, hcount, vcount
// - display fetch side   : disp_req, disp_addr -> disp_rvalid
// - writer side          : wr_req[1:0], wr_addr0/1, wr_data0/1 -> wr_ack[1:0], starve[1:0]
// - memory side          : mem_en, mem_we, mem_addr, mem_wdata
// Modport slave is the scheduler; modport master is everything around it.
interface vram_scheduler_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 8
);

  logic              bright;
  logic [9:0]        hcount;
  logic [9:0]        vcount;
  logic              disp_req;
  logic [ADDR_W-1:0] disp_addr;
  logic              disp_rvalid;
  logic [1:0]        wr_req;
  logic [ADDR_W-1:0] wr_addr0;
  logic [ADDR_W-1:0] wr_addr1;
  logic [DATA_W-1:0] wr_data0;
  logic [DATA_W-1:0] wr_data1;
  logic [1:0]        wr_ack;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [1:0]        starve;

  modport master (
    output bright, hcount, vcount, disp_req, disp_addr,
    output wr_req, wr_addr0, wr_addr1, wr_data0, wr_data1,
    input  disp_rvalid, wr_ack, mem_en, mem_we, mem_addr, mem_wdata, starve
  );

  modport slave (
    input  bright, hcount, vcount, disp_req, disp_addr,
    input  wr_req, wr_addr0, wr_addr1, wr_data0, wr_data1,
    output disp_rvalid, wr_ack, mem_en, mem_we, mem_addr, mem_wdata, starve
  );

endinterface

// File: rtl/vram_scheduler_starve_monitor.sv
// Per-writer starvation monitor.
// - clk, rst     : system clock, asynchronous active-low reset
// - req, ack     : writer request and its registered acknowledge
// - frame_start  : first pixel of a frame, clears the sticky flag
// - starve       : sticky flag, set once req has waited MAX_WAIT cycles
module starve_monitor #(
  parameter int MAX_WAIT = 1023
) (
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic ack,
  input  logic frame_start,
  output logic starve
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  logic [CNT_W-1:0] cnt_reg;
  logic             pending;
  logic             reach;
  logic             starve_reg;

  assign pending = req && !ack;
  // Counter is about to hit (or already sits at) the limit this cycle.
  assign reach   = pending && (cnt_reg >= CNT_W'(MAX_WAIT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg    <= '0;
      starve_reg <= 1'b0;
    end else begin
      if (!pending) begin
        cnt_reg <= '0;
      end else if (cnt_reg != CNT_W'(MAX_WAIT)) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
      // A new starvation event beats the frame-start clear.
      if (reach) begin
        starve_reg <= 1'b1;
      end else if (frame_start) begin
        starve_reg <= 1'b0;
      end
    end
  end

  assign starve = starve_reg;

endmodule

// File: rtl/vram_scheduler.sv
// Single-port VRAM access scheduler.
// Display fetches always win; two writers share the remaining cycles
// round-robin, optionally only while bright=0. All memory-side outputs are
// registered, so a decision taken in cycle n is visible after edge n+1.
// - clk, rst : system clock, asynchronous active-low reset
// - bus      : vram_scheduler_if.slave (sync, display, writer and memory signals)
module vram_scheduler
  import vga_pkg::*;
#(
  parameter int ADDR_W     = 15,
  parameter int DATA_W     = 8,
  parameter int READ_LAT   = 2,
  parameter int BLANK_ONLY = 1,
  parameter int MAX_WAIT   = 1023
) (
  input  logic            clk,
  input  logic            rst,
  vram_scheduler_if.slave bus
);

  sched_state_t      state_reg, state_next;
  logic              rr_reg, rr_next;
  logic              mem_en_reg, mem_en_next;
  logic              mem_we_reg, mem_we_next;
  logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
  logic [DATA_W-1:0] mem_wdata_reg, mem_wdata_next;
  logic [1:0]        wr_ack_reg, wr_ack_next;

  logic              window_open;
  logic [1:0]        eligible;
  logic              win_sel;
  logic              frame_start;
  logic [1:0]        starve_vec;
  logic              rd_issued;
  logic [READ_LAT-1:0] rd_pipe_reg;

  assign window_open = (BLANK_ONLY != 0) ? !bus.bright : 1'b1;
  assign frame_start = is_frame_start(bus.hcount, bus.vcount);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_writer
      localparam sched_state_t WR_ST = (gi == 0) ? ST_WR0 : ST_WR1;

      // The writer acked last cycle is masked so a request that is still
      // high while the requester sees its ack is not granted twice.
      assign eligible[gi] = bus.wr_req[gi] && (state_reg != WR_ST);

      starve_monitor #(
        .MAX_WAIT(MAX_WAIT)
      ) u_starve (
        .clk        (clk),
        .rst        (rst),
        .req        (bus.wr_req[gi]),
        .ack        (wr_ack_reg[gi]),
        .frame_start(frame_start),
        .starve     (starve_vec[gi])
      );
    end
  endgenerate

  always_comb begin
    state_next     = ST_IDLE;
    rr_next        = rr_reg;
    mem_en_next    = 1'b0;
    mem_we_next    = 1'b0;
    mem_addr_next  = mem_addr_reg;
    mem_wdata_next = mem_wdata_reg;
    wr_ack_next    = 2'b00;
    win_sel        = 1'b0;

    if (bus.disp_req) begin
      mem_en_next   = 1'b1;
      mem_addr_next = bus.disp_addr;
      state_next    = ST_RD;
    end else if (window_open && (eligible != 2'b00)) begin
      win_sel        = (eligible == 2'b11) ? rr_reg : eligible[1];
      mem_en_next    = 1'b1;
      mem_we_next    = 1'b1;
      mem_addr_next  = win_sel ? bus.wr_addr1 : bus.wr_addr0;
      mem_wdata_next = win_sel ? bus.wr_data1 : bus.wr_data0;
      wr_ack_next    = win_sel ? 2'b10 : 2'b01;
      rr_next        = !win_sel;
      state_next     = win_sel ? ST_WR1 : ST_WR0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= ST_IDLE;
      rr_reg        <= 1'b0;
      mem_en_reg    <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      wr_ack_reg    <= 2'b00;
    end else begin
      state_reg     <= state_next;
      rr_reg        <= rr_next;
      mem_en_reg    <= mem_en_next;
      mem_we_reg    <= mem_we_next;
      mem_addr_reg  <= mem_addr_next;
      mem_wdata_reg <= mem_wdata_next;
      wr_ack_reg    <= wr_ack_next;
    end
  end

  // Read-valid pipe fed by the registered read strobe: valid arrives
  // READ_LAT cycles after mem_en for a read.
  assign rd_issued = mem_en_reg && !mem_we_reg;

  generate
    for (gi = 0; gi < READ_LAT; gi++) begin : g_rd_pipe
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          rd_pipe_reg[gi] <= 1'b0;
        end else if (gi == 0) begin
          rd_pipe_reg[gi] <= rd_issued;
        end else begin
          rd_pipe_reg[gi] <= rd_pipe_reg[(gi == 0) ? 0 : gi - 1];
        end
      end
    end
  endgenerate

  assign bus.mem_en      = mem_en_reg;
  assign bus.mem_we      = mem_we_reg;
  assign bus.mem_addr    = mem_addr_reg;
  assign bus.mem_wdata   = mem_wdata_reg;
  assign bus.wr_ack      = wr_ack_reg;
  assign bus.disp_rvalid = rd_pipe_reg[READ_LAT-1];
  assign bus.starve      = starve_vec;

endmodule
